// File: rtl/jdquant_pkg.sv
// Shared widths, FSM state type and output saturation limits for the dequantizer.
package jdquant_pkg;
    localparam int DW_DEF     = 16;
    localparam int QW_DEF     = 8;
    localparam int QDEPTH_DEF = 64;

    localparam int SAT_MAX = (2 ** (DW_DEF - 1)) - 1;
    localparam int SAT_MIN = -(2 ** (DW_DEF - 1));

    typedef enum logic {LOAD, RUN} fsmState_t;
endpackage

// File: rtl/jdquant_qtab_ram.sv
// Quantizer table storage: one synchronous write port, one asynchronous read port.
module jdquant_qtab_ram #(
    parameter int QW     = 8,
    parameter int QDEPTH = 64,
    localparam int AW    = $clog2(QDEPTH)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [QW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [QW-1:0] rdata
);
    // No reset: table contents deliberately survive reset.
    logic [QW-1:0] mem [QDEPTH];

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/jdquant_dequant_core.sv
// Loads a zigzag quantizer table, then multiplies each coefficient by its entry with saturation.
module jdquant_dequant_core
    import jdquant_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int QW     = QW_DEF,
    parameter int QDEPTH = QDEPTH_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [QW-1:0]        qtab_d,
    input  logic                 qtab_e,
    input  logic                 qtab_v,
    output logic                 qtab_b,
    input  logic signed [DW-1:0] inStream_d,
    input  logic                 inStream_e,
    input  logic                 inStream_v,
    output logic                 inStream_b,
    output logic signed [DW-1:0] outStream_d,
    output logic                 outStream_e,
    output logic                 outStream_v,
    input  logic                 outStream_b
);
    localparam int AW = $clog2(QDEPTH);
    localparam int PW = DW + QW;
    localparam logic signed [PW-1:0] SAT_HI = PW'(SAT_MAX);
    localparam logic signed [PW-1:0] SAT_LO = PW'(SAT_MIN);

    fsmState_t state, stateNext;
    logic [AW-1:0] widx, ridx;
    logic [QW-1:0] qEntry;
    logic inReady, qXfer, inXfer, outXfer;
    logic signed [PW-1:0] coefExt, qExt, prod;
    logic signed [DW-1:0] satD;

    // Transfer qualifiers derived from state directly, avoiding a loop through the _b outputs.
    assign inReady = ~(outStream_v & outStream_b);
    assign qXfer   = qtab_v & (state == LOAD);
    assign inXfer  = inStream_v & (state == RUN) & inReady;
    assign outXfer = outStream_v & ~outStream_b;

    jdquant_qtab_ram #(.QW(QW), .QDEPTH(QDEPTH)) uQtab (
        .clock (clock),
        .we    (qXfer & ~qtab_e),
        .waddr (widx),
        .wdata (qtab_d),
        .raddr (ridx),
        .rdata (qEntry)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= LOAD;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext  = state;
        qtab_b     = 1'b1;
        inStream_b = 1'b1;
        case (state)
            LOAD: begin
                qtab_b = 1'b0;
                if (qXfer && (qtab_e || (&widx))) stateNext = RUN;
            end
            RUN: begin
                inStream_b = ~inReady;
                if (inXfer && inStream_e) stateNext = LOAD;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            widx <= '0;
            ridx <= '0;
        end else begin
            if (qXfer) widx <= qtab_e ? '0 : widx + 1'b1;
            if (inXfer) ridx <= inStream_e ? '0 : ridx + 1'b1;
        end
    end

    // Signed coefficient times zero-extended table entry; the PW-bit product cannot overflow.
    always_comb begin
        coefExt = PW'(inStream_d);
        qExt    = PW'({1'b0, qEntry});
        prod    = coefExt * qExt;
        if (prod > SAT_HI)      satD = SAT_HI[DW-1:0];
        else if (prod < SAT_LO) satD = SAT_LO[DW-1:0];
        else                    satD = prod[DW-1:0];
    end

    // A new load wins over a drain in the same cycle, so a pass-through never drops a word.
    always_ff @(posedge clock) begin
        if (reset) begin
            outStream_v <= 1'b0;
            outStream_e <= 1'b0;
            outStream_d <= '0;
        end else if (inXfer) begin
            outStream_v <= 1'b1;
            outStream_e <= inStream_e;
            outStream_d <= inStream_e ? '0 : satD;
        end else if (outXfer) begin
            outStream_v <= 1'b0;
        end
    end
endmodule

// File: tb/tb_jdquant_dequant_core.sv
// Directed self-checking bench for jdquant_dequant_core with hand-computed expectations.
module tb_jdquant_dequant_core;
    logic               clock = 1'b0;
    logic               reset;
    logic [7:0]         qtab_d;
    logic               qtab_e, qtab_v, qtab_b;
    logic signed [15:0] inStream_d;
    logic               inStream_e, inStream_v, inStream_b;
    logic signed [15:0] outStream_d;
    logic               outStream_e, outStream_v, outStream_b;

    int errors = 0;
    int checks = 0;
    int outCnt = 0;

    jdquant_dequant_core #(.DW(16), .QW(8), .QDEPTH(64)) dut (
        .clock       (clock),
        .reset       (reset),
        .qtab_d      (qtab_d),
        .qtab_e      (qtab_e),
        .qtab_v      (qtab_v),
        .qtab_b      (qtab_b),
        .inStream_d  (inStream_d),
        .inStream_e  (inStream_e),
        .inStream_v  (inStream_v),
        .inStream_b  (inStream_b),
        .outStream_d (outStream_d),
        .outStream_e (outStream_e),
        .outStream_v (outStream_v),
        .outStream_b (outStream_b)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (outStream_v && !outStream_b) outCnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // mode 0: entries 1..64, mode 1: entries 255 down to 192
    task automatic load_table(input int mode);
        for (int i = 0; i < 64; i++) begin
            qtab_v = 1'b1;
            qtab_e = 1'b0;
            qtab_d = (mode == 0) ? 8'(i + 1) : 8'(255 - i);
            tick();
        end
        qtab_v = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (outStream_v !== 1'b0) begin errors++; $display("FAIL reset_v: got %0b expected 0", outStream_v); end
        checks++; if (outStream_e !== 1'b0) begin errors++; $display("FAIL reset_e: got %0b expected 0", outStream_e); end
        checks++; if (outStream_d !== 16'sd0) begin errors++; $display("FAIL reset_d: got %0d expected 0", outStream_d); end
        checks++; if (qtab_b !== 1'b0) begin errors++; $display("FAIL reset_qtab_b: got %0b expected 0", qtab_b); end
        checks++; if (inStream_b !== 1'b1) begin errors++; $display("FAIL reset_inStream_b: got %0b expected 1", inStream_b); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        load_table(0);
        checks++; if (qtab_b !== 1'b1) begin errors++; $display("FAIL basic_run_qtab_b: got %0b expected 1", qtab_b); end
        checks++; if (inStream_b !== 1'b0) begin errors++; $display("FAIL basic_run_inStream_b: got %0b expected 0", inStream_b); end
        for (int i = 0; i < 64; i++) begin
            inStream_v = 1'b1;
            inStream_e = 1'b0;
            inStream_d = 16'sd2;
            tick();
            checks++;
            if (outStream_v !== 1'b1 || outStream_e !== 1'b0 || outStream_d !== 16'(2 * (i + 1))) begin
                errors++;
                $display("FAIL basic_word%0d: got v=%0b e=%0b d=%0d expected v=1 e=0 d=%0d",
                         i, outStream_v, outStream_e, outStream_d, 2 * (i + 1));
            end
        end
        inStream_v = 1'b0;
        tick();
        checks++; if (outStream_v !== 1'b0) begin errors++; $display("FAIL basic_drain_v: got %0b expected 0", outStream_v); end
    endtask

    task automatic test_token();
        for (int i = 0; i < 10; i++) begin
            inStream_v = 1'b1;
            inStream_e = 1'b0;
            inStream_d = 16'sd1;
            tick();
            checks++;
            if (outStream_d !== 16'(i + 1)) begin
                errors++; $display("FAIL token_pre%0d: got %0d expected %0d", i, outStream_d, i + 1);
            end
        end
        inStream_e = 1'b1;
        inStream_d = 16'sd5;
        tick();
        inStream_v = 1'b0;
        inStream_e = 1'b0;
        checks++;
        if (outStream_v !== 1'b1 || outStream_e !== 1'b1 || outStream_d !== 16'sd0) begin
            errors++; $display("FAIL token_out: got v=%0b e=%0b d=%0d expected v=1 e=1 d=0", outStream_v, outStream_e, outStream_d);
        end
        checks++; if (qtab_b !== 1'b0) begin errors++; $display("FAIL token_qtab_b: got %0b expected 0", qtab_b); end
        load_table(1);
        checks++; if (outStream_v !== 1'b0) begin errors++; $display("FAIL token_drained_in_load: got %0b expected 0", outStream_v); end
        inStream_v = 1'b1;
        inStream_d = 16'sd1;
        tick();
        checks++; if (outStream_d !== 16'sd255) begin errors++; $display("FAIL token_newblk0: got %0d expected 255", outStream_d); end
        tick();
        checks++; if (outStream_d !== 16'sd254) begin errors++; $display("FAIL token_newblk1: got %0d expected 254", outStream_d); end
    endtask

    // ridx enters at 2: entries 253, 252, 251, 250
    task automatic test_saturation();
        inStream_v = 1'b1;
        inStream_d = 16'sd200;
        tick();
        checks++; if (outStream_d !== 16'sd32767) begin errors++; $display("FAIL sat_pos: got %0d expected 32767", outStream_d); end
        inStream_d = -16'sd200;
        tick();
        checks++; if (outStream_d !== -16'sd32768) begin errors++; $display("FAIL sat_neg: got %0d expected -32768", outStream_d); end
        inStream_d = 16'sd130;
        tick();
        checks++; if (outStream_d !== 16'sd32630) begin errors++; $display("FAIL sat_near_pos: got %0d expected 32630", outStream_d); end
        inStream_d = -16'sd131;
        tick();
        checks++; if (outStream_d !== -16'sd32750) begin errors++; $display("FAIL sat_near_neg: got %0d expected -32750", outStream_d); end
        inStream_v = 1'b0;
        tick();
    endtask

    // ridx enters at 6: entries 249, 248, 247
    task automatic test_back_to_back();
        int cnt0;
        cnt0 = outCnt;
        outStream_b = 1'b1;
        inStream_v  = 1'b1;
        inStream_d  = 16'sd1;
        tick();
        checks++; if (outStream_v !== 1'b1 || outStream_d !== 16'sd249) begin errors++; $display("FAIL stall_first: got v=%0b d=%0d expected v=1 d=249", outStream_v, outStream_d); end
        inStream_d = 16'sd2;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (inStream_b !== 1'b1 || outStream_d !== 16'sd249 || outStream_v !== 1'b1) begin
                errors++; $display("FAIL stall_hold%0d: got b=%0b v=%0b d=%0d expected b=1 v=1 d=249", k, inStream_b, outStream_v, outStream_d);
            end
            tick();
        end
        outStream_b = 1'b0;
        #1;
        checks++; if (inStream_b !== 1'b0) begin errors++; $display("FAIL stall_release_b: got %0b expected 0", inStream_b); end
        tick();
        checks++; if (outStream_d !== 16'sd496) begin errors++; $display("FAIL stall_resume0: got %0d expected 496", outStream_d); end
        inStream_d = 16'sd3;
        tick();
        checks++; if (outStream_d !== 16'sd741) begin errors++; $display("FAIL stall_resume1: got %0d expected 741", outStream_d); end
        inStream_v = 1'b0;
        tick();
        checks++; if (outStream_v !== 1'b0) begin errors++; $display("FAIL stall_drain_v: got %0b expected 0", outStream_v); end
        checks++; if (outCnt - cnt0 !== 3) begin errors++; $display("FAIL stall_xfer_count: got %0d expected 3", outCnt - cnt0); end
    endtask

    // Mid-block token at ridx 9, then a short table of 7s ended by a qtab token.
    task automatic test_qtab_token();
        int expv [5] = '{7, 7, 7, 252, 251};
        inStream_v = 1'b1;
        inStream_e = 1'b1;
        tick();
        inStream_v = 1'b0;
        inStream_e = 1'b0;
        checks++; if (outStream_e !== 1'b1 || outStream_d !== 16'sd0) begin errors++; $display("FAIL midtoken_out: got e=%0b d=%0d expected e=1 d=0", outStream_e, outStream_d); end
        for (int i = 0; i < 3; i++) begin
            qtab_v = 1'b1;
            qtab_e = 1'b0;
            qtab_d = 8'd7;
            tick();
        end
        qtab_e = 1'b1;
        qtab_d = 8'd99;
        tick();
        qtab_v = 1'b0;
        qtab_e = 1'b0;
        checks++; if (qtab_b !== 1'b1) begin errors++; $display("FAIL qtoken_run: got qtab_b=%0b expected 1", qtab_b); end
        for (int i = 0; i < 5; i++) begin
            inStream_v = 1'b1;
            inStream_d = 16'sd1;
            tick();
            checks++;
            if (outStream_d !== 16'(expv[i])) begin errors++; $display("FAIL qtoken_word%0d: got %0d expected %0d", i, outStream_d, expv[i]); end
        end
        inStream_v = 1'b0;
        tick();
    endtask

    // ridx enters at 5 (entry 250); the table of 7s must survive reset.
    task automatic test_reset_mid();
        outStream_b = 1'b1;
        inStream_v  = 1'b1;
        inStream_d  = 16'sd1;
        tick();
        checks++; if (outStream_v !== 1'b1 || outStream_d !== 16'sd250) begin errors++; $display("FAIL rstmid_pending: got v=%0b d=%0d expected v=1 d=250", outStream_v, outStream_d); end
        inStream_v = 1'b0;
        reset = 1'b1;
        tick();
        checks++; if (outStream_v !== 1'b0) begin errors++; $display("FAIL rstmid_v: got %0b expected 0", outStream_v); end
        checks++; if (outStream_d !== 16'sd0) begin errors++; $display("FAIL rstmid_d: got %0d expected 0", outStream_d); end
        checks++; if (qtab_b !== 1'b0) begin errors++; $display("FAIL rstmid_qtab_b: got %0b expected 0", qtab_b); end
        checks++; if (inStream_b !== 1'b1) begin errors++; $display("FAIL rstmid_inStream_b: got %0b expected 1", inStream_b); end
        reset = 1'b0;
        outStream_b = 1'b0;
        qtab_v = 1'b1;
        qtab_e = 1'b1;
        tick();
        qtab_v = 1'b0;
        qtab_e = 1'b0;
        inStream_v = 1'b1;
        inStream_d = 16'sd1;
        tick();
        inStream_v = 1'b0;
        checks++; if (outStream_d !== 16'sd7) begin errors++; $display("FAIL rstmid_table_kept: got %0d expected 7", outStream_d); end
        tick();
    endtask

    initial begin
        reset = 1'b1;
        qtab_d = '0; qtab_e = 1'b0; qtab_v = 1'b0;
        inStream_d = '0; inStream_e = 1'b0; inStream_v = 1'b0;
        outStream_b = 1'b0;
        test_reset();
        test_basic();
        test_token();
        test_saturation();
        test_back_to_back();
        test_qtab_token();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
